// File: rtl/enduro_pkt_pkg.sv
// Shared types and width helpers for the enduro stream packetizer.
//   pkt_state_t : packetizer FSM states
//   cnt_bits()  : width needed to hold values 0..max_val (at least 1 bit)
package enduro_pkt_pkg;

  typedef enum logic [1:0] {
    PKT_EMPTY,  // hold register empty
    PKT_HOLD,   // one beat held as lookahead
    PKT_CLOSE   // held beat is the last of its packet, waiting for O
  } pkt_state_t;

  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/enduro_axis_reg_slice.sv
// One-entry AXI4-Stream register with data+last payload.
//   in_valid/in_data/in_last : beat to load, taken whenever in_free
//   in_free                  : register empty or being drained this cycle
//   out_valid/out_data/out_last/out_ready : registered AXI4-Stream master side
module enduro_axis_reg_slice #(
  parameter int W = 32
) (
  input  logic         axis_clk,
  input  logic         axis_aresetn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_free,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready
);

  assign in_free = !out_valid || out_ready;

  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_free) begin
      out_valid <= in_valid;
      out_last  <= in_valid && in_last;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/enduro_axis_packetizer.sv
// Groups a continuous AXI4-Stream word flow into packets by generating tlast.
// One beat is held back (H) so tlast can be attached to the final beat once the
// packet closes: on MAX_PKT_LEN beats, on TIMEOUT_CYCLES idle cycles, or on flush.
//   axis_clk/axis_aresetn : clock, async active-low reset
//   s_axis_*              : input stream (tvalid/tready/tdata)
//   m_axis_*              : output stream (tvalid/tready/tdata/tlast), driven by O
//   flush                 : pulse, close the current packet
//   pkt_count             : packets emitted (wraps)
//   pkt_done              : registered pulse, cycle after a tlast handshake
module enduro_axis_packetizer
  import enduro_pkt_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_PKT_LEN    = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  axis_clk,
  input  logic                  axis_aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  pkt_done
);

  localparam int BW = cnt_bits(MAX_PKT_LEN);
  localparam int IW = cnt_bits(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_PKT_LEN);
  localparam logic [IW-1:0] IMAX = IW'(TIMEOUT_CYCLES - 1);

  pkt_state_t            state;
  logic [DATA_WIDTH-1:0] h_data;
  logic [BW-1:0]         beat_cnt;
  logic [IW-1:0]         idle_cnt;
  logic h_valid, o_free, accept, at_max, closing, shift, o_load, m_last_hs;

  assign h_valid       = (state != PKT_EMPTY);
  assign s_axis_tready = axis_aresetn && (!h_valid || o_free);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign at_max        = (state == PKT_HOLD) && (beat_cnt == BMAX);
  // closing: held beat leaves for O with tlast this cycle
  assign closing       = o_free && ((state == PKT_CLOSE) || at_max);
  // shift: held beat leaves for O as a middle beat, replaced by the new one
  assign shift         = (state == PKT_HOLD) && !at_max && accept;
  assign o_load        = closing || shift;
  assign m_last_hs     = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state    <= PKT_EMPTY;
      h_data   <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      if (accept || !h_valid) idle_cnt <= '0;
      else if (idle_cnt != IMAX) idle_cnt <= idle_cnt + IW'(1);

      case (state)
        PKT_EMPTY: if (accept) begin
          h_data   <= s_axis_tdata;
          beat_cnt <= beat_cnt + BW'(1);
          state    <= PKT_HOLD;
        end
        PKT_HOLD: begin
          if (at_max) begin
            if (!o_free) state <= PKT_CLOSE;
          end else if (accept) begin
            h_data   <= s_axis_tdata;
            beat_cnt <= beat_cnt + BW'(1);
          end else if (flush || idle_cnt == IMAX) begin
            state <= PKT_CLOSE;
          end
        end
        PKT_CLOSE: ;  // flush absorbed; exit handled by closing below
        default: state <= PKT_EMPTY;
      endcase

      // Final beat goes out; a beat accepted alongside starts the next packet.
      if (closing) begin
        if (accept) begin
          h_data   <= s_axis_tdata;
          beat_cnt <= BW'(1);
          state    <= PKT_HOLD;
        end else begin
          beat_cnt <= '0;
          state    <= PKT_EMPTY;
        end
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      pkt_count <= '0;
      pkt_done  <= 1'b0;
    end else begin
      pkt_done <= m_last_hs;
      if (m_last_hs) pkt_count <= pkt_count + CNT_WIDTH'(1);
    end
  end

  enduro_axis_reg_slice #(.W(DATA_WIDTH)) u_oreg (
    .axis_clk     (axis_clk),
    .axis_aresetn (axis_aresetn),
    .in_valid     (o_load),
    .in_data      (h_data),
    .in_last      (closing),
    .in_free      (o_free),
    .out_valid    (m_axis_tvalid),
    .out_data     (m_axis_tdata),
    .out_last     (m_axis_tlast),
    .out_ready    (m_axis_tready)
  );

endmodule
